// File: rtl/imem_loader.sv
// imem_loader: writer-side loader for the processor's read-only instruction memory.
//
// Accepts a framed byte stream (length hi, length lo, N x 4 data bytes, MSB first)
// and writes the assembled 32-bit words to consecutive word addresses starting at 0.
// The processor is held off (cpu_hold) for the whole load.
//
// Optional feature macro: IMEM_LOADER_CKSUM_EN
//   When defined, a trailing 8-bit checksum byte (sum of data bytes mod 256) is
//   accepted after the data; a mismatch sets err.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   start             one-cycle load request, sampled only in IDLE
//   rx_data/rx_valid  input byte stream; rx_ready says a byte is taken this cycle
//   im_we/im_addr/im_wdata  instruction memory write port (one cycle per word)
//   cpu_hold, busy    high while the loader is not idle
//   done              one-cycle pulse at end of a load
//   err               sticky error flag, cleared by the next accepted start
module imem_loader #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [DW-1:0] im_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrite, StCksum, StDone
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrite, StDone
    } state_e;
`endif

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [DW-1:0] word_q, word_d;
    logic [AW-1:0] im_addr_q, im_addr_d;
    logic [DW-1:0] im_wdata_q, im_wdata_d;
    logic          err_q, err_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    logic        xfer;
    logic [15:0] len_full;

    assign len_full = {len_q[15:8], rx_data};

    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            StLenHi, StLenLo, StData: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum:                  rx_ready = 1'b1;
`endif
            default:                  rx_ready = 1'b0;
        endcase
    end

    assign xfer = rx_valid & rx_ready;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        err_d      = err_q;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLenHi;
                    err_d      = 1'b0;
                    addr_d     = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_d      = 8'h00;
`endif
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = rx_data;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    // Lengths beyond memory capacity are rejected before any write.
                    if ({16'h0000, len_full} > (32'd1 << AW)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (len_full == 16'h0000) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_d = StCksum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    word_d     = {word_q[DW-9:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_d      = sum_q + rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Capture the write port values so they hold after WRITE.
                        state_d    = StWrite;
                        im_addr_d  = addr_q;
                        im_wdata_d = word_d;
                    end
                end
            end
            StWrite: begin
                addr_d     = addr_q + 1'b1;
                word_cnt_d = word_cnt_q + 16'd1;
                if (word_cnt_d == len_q) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    state_d = StCksum;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StData;
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum: begin
                if (xfer) begin
                    if (rx_data != sum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            len_q      <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign im_we    = (state_q == StWrite);
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign busy     = (state_q != StIdle);
    assign cpu_hold = busy;
    assign done     = (state_q == StDone);
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized frames checked
// against a frame-level model (expected word list, checksum by plain summation).
module tb_imem_loader;

    localparam int unsigned AW = 10;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.AW(AW), .DW(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [7:0]    tx_q[$];
    logic [31:0]   exp_w[$];
    logic [AW-1:0] got_a[$];
    logic [31:0]   got_d[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port and done monitor.
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            got_a.push_back(im_addr);
            got_d.push_back(im_wdata);
            chk("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
        end
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- frame-level reference model ----------------
    task automatic new_frame();
        tx_q.delete();
        exp_w.delete();
    endtask

    task automatic add_len(input int n);
        tx_q.push_back(8'((n >> 8) & 255));
        tx_q.push_back(8'(n & 255));
    endtask

    task automatic add_word(input logic [31:0] w);
        exp_w.push_back(w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    // Appends the checksum byte (corrupted if bad) when the feature is built in.
    task automatic add_cksum(input bit bad);
`ifdef IMEM_LOADER_CKSUM_EN
        int s;
        s = 0;
        foreach (exp_w[i]) begin
            s = s + int'(exp_w[i][31:24]) + int'(exp_w[i][23:16])
                  + int'(exp_w[i][15:8]) + int'(exp_w[i][7:0]);
        end
        s = (s + (bad ? 1 : 0)) % 256;
        tx_q.push_back(8'(s));
`else
        if (bad) begin end
`endif
    endtask

    function automatic bit err_for(input bit bad);
`ifdef IMEM_LOADER_CKSUM_EN
        return bad;
`else
        if (bad) begin end
        return 1'b0;
`endif
    endfunction

    // ---------------- drivers ----------------
    // gap_mode: 0 no gaps, 1 idle cycle before every byte, 2 random idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        bit taken;
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            @(posedge CLK);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        taken    = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (rx_ready === 1'b1) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) chk("rx_ready_timeout", 64'd0, 64'd1);
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_all(input int gap_mode);
        foreach (tx_q[i]) send_byte(tx_q[i], gap_mode);
    endtask

    task automatic begin_frame(input string tag);
        got_a.delete();
        got_d.delete();
        done_cnt = 0;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_hold"}, {63'd0, cpu_hold}, 64'd1);
        chk({tag, "_err_clr"}, {63'd0, err}, 64'd0);
    endtask

    task automatic finish_frame(input string tag, input int gap_mode, input bit exp_err,
                                input int exp_done);
        send_all(gap_mode);
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (busy === 1'b0) break;
        end
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hold_off"}, {63'd0, cpu_hold}, 64'd0);
        chk({tag, "_nwrites"}, 64'(got_a.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got_a.size(); i++) begin
            chk({tag, "_addr"}, 64'(got_a[i]), 64'(i));
            chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_w[i]));
        end
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        chk({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, {63'd0, im_we}, 64'd0);
        chk({tag, "_addr"}, 64'(im_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(im_wdata), 64'd0);
        chk({tag, "_hold"}, {63'd0, cpu_hold}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
        chk({tag, "_rdy"}, {63'd0, rx_ready}, 64'd0);
    endtask

    initial begin
        int  n;
        bit  bad;

        RST      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk_all_zero("post_reset");

        // Directed two-word frame, no gaps.
        new_frame();
        add_len(2);
        add_word(32'h12345678);
        add_word(32'h9ABCDEF0);
        add_cksum(1'b0);
        begin_frame("basic");
        finish_frame("basic", 0, 1'b0, 1);

        // Same frame with rx_valid toggling every cycle.
        begin_frame("toggle");
        finish_frame("toggle", 1, 1'b0, 1);

        // Length overflow: 1025 words with AW=10.
        new_frame();
        add_len(1025);
        begin_frame("ovf");
        finish_frame("ovf", 0, 1'b1, 0);

        // Next start clears err; complete it as a zero-length load.
        new_frame();
        add_len(0);
        add_cksum(1'b0);
        begin_frame("zero");
        finish_frame("zero", 0, 1'b0, 1);

`ifdef IMEM_LOADER_CKSUM_EN
        new_frame();
        add_len(1);
        add_word(32'h01020304);
        add_cksum(1'b0);
        begin_frame("ck_good");
        finish_frame("ck_good", 0, 1'b0, 1);

        new_frame();
        add_len(1);
        add_word(32'h01020304);
        add_cksum(1'b1);
        begin_frame("ck_bad");
        finish_frame("ck_bad", 0, 1'b1, 1);
`endif

        // Randomized frames.
        for (int t = 0; t < 4; t++) begin
            n   = int'($urandom_range(1, 6));
            bad = 1'($urandom_range(0, 1));
            new_frame();
            add_len(n);
            for (int i = 0; i < n; i++) add_word($urandom);
            add_cksum(bad);
            begin_frame("rand");
            finish_frame("rand", 2, err_for(bad), 1);
        end

        // Reset after the second data byte of a two-word frame.
        new_frame();
        add_len(2);
        add_word($urandom);
        add_word($urandom);
        add_cksum(1'b0);
        begin_frame("midrst");
        for (int i = 0; i < 4; i++) send_byte(tx_q[i], 0);
        RST = 1'b1;
        #1;
        chk_all_zero("midrst");
        chk("midrst_nowrite", 64'(got_a.size()), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        begin_frame("reload");
        finish_frame("reload", 0, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the processor's read-only instruction memory.
- Accepts a framed byte stream and assembles big-endian 32-bit words.
- Writes the words to consecutive word addresses through the instruction memory write port, starting at 0. The PC steps by 1 per instruction, so addresses step by 1 per word.
- Holds the processor off (cpu_hold) for the whole load so fetch never sees a partial program.

Parameters:
AW, 10, instruction memory word-address width; capacity 2^AW words
DW, 32, instruction word width; fixed at 32, 4 bytes per word

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  asynchronous reset, active-high
start  input  1  one-cycle request to begin a load; sampled only in IDLE
rx_data  input  8  stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
im_we  output  1  instruction memory write enable, one cycle per word
im_addr  output  AW  word address for the write
im_wdata  output  32  word to write
cpu_hold  output  1  processor must stall/reset while high
busy  output  1  loader not in IDLE
done  output  1  one-cycle pulse at end of load
err  output  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset: asynchronous, active-high, CLK is the only clock. State goes to IDLE. All outputs are 0, including cpu_hold. The address counter, byte counter, word counter and assembly register are all 0.
- Byte transfer: a byte is taken on a cycle with rx_valid & rx_ready. rx_ready is combinational from state only; it is 1 in LEN_HI, LEN_LO, DATA and CKSUM, and 0 elsewhere.
- Frame format: length high byte, length low byte, then N×4 data bytes. N is the 16-bit word count. Each word is sent MSB first.
- Optional trailing checksum byte: see Optional Feature.
- IDLE:
  - start=1 → LEN_HI.
  - An accepted start also clears err and the address counter.
  - start in any other state is ignored.
- LEN_HI: on transfer, latch N[15:8] → LEN_LO.
- LEN_LO, on transfer, latch N[7:0], then:
  - N > 2^AW: set err → IDLE. No writes occur.
  - N = 0: → CKSUM if the feature is enabled, else → DONE.
  - Otherwise → DATA.
- DATA:
  - On each transfer, shift the byte into the assembly register: word = {word[23:0], rx_data}.
  - Byte counter 0..3. On the 4th byte → WRITE.
- WRITE (exactly 1 cycle):
  - im_we=1, im_addr = address counter, im_wdata = assembled word.
  - Next edge: address counter +1, word counter +1.
  - If the word counter reaches N → CKSUM (feature enabled) or DONE; else → DATA.
- WRITE latency: im_we asserts on the cycle after the edge that accepted the 4th byte of a word.
- DONE: done=1 for one cycle → IDLE.
- cpu_hold = busy = (state != IDLE). It drops on the edge leaving DONE.
- Address counter: AW bits. N ≤ 2^AW guarantees no wrap within a load. With N = 2^AW the counter wraps to 0 after the final write, which is harmless because the load is ending.
- Outputs when not in WRITE: im_we=0; im_addr and im_wdata hold their last values.
- Reset mid-load: abort immediately. Words already written remain in memory. cpu_hold drops. err is not set.
- rx_valid with rx_ready=0 (IDLE, WRITE, DONE): the byte is not consumed. The source must hold it.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Enabled:
  - An 8-bit running sum of all data bytes is kept, mod 256; the length bytes are excluded. It is cleared on start.
  - After the last WRITE (or directly after LEN_LO when N=0), state CKSUM accepts one byte.
  - If that byte ≠ the running sum, set err.
  - → DONE; done pulses regardless of the result.
- Disabled: no CKSUM state and no sum register. err is set only by length overflow.

Test Plan:
- Reset, then start; stream 00 02 12 34 56 78 9A BC DE F0 → im_we pulses twice: addr 0 data 0x12345678, then addr 1 data 0x9ABCDEF0. done pulses once. cpu_hold high from the cycle after start through DONE. err=0.
- Same frame with rx_valid toggling 1/0 every cycle → identical writes. No byte lost or duplicated. rx_ready=0 during WRITE.
- Length 04 01 with AW=10 (1025 > 1024) → err=1, no im_we, return to IDLE. A following start clears err.
- Length 00 00 → no writes, done pulses. With IMEM_LOADER_CKSUM_EN, checksum byte 00 gives err=0.
- IMEM_LOADER_CKSUM_EN with 00 01 01 02 03 04 and checksum 0A → err=0. Checksum 0B → err=1, word still written to addr 0, done pulses.
- RST asserted after the 2nd data byte of a 2-word frame → all outputs 0 immediately, state IDLE, no im_we. A new start reloads from addr 0.
